// File: rtl/adder_pkg.sv
// Shared constants and sizing helper for the registered carry-lookahead adder.
package adder_pkg;

    localparam int ADDER_MAX_WIDTH = 64;
    localparam int CLA_GROUP       = 4;

    // Number of 4-bit lookahead groups needed to cover a given operand width.
    function automatic int num_groups(input int width);
        return (width + CLA_GROUP - 1) / CLA_GROUP;
    endfunction

endpackage

// File: rtl/cla4_group.sv
// One 4-bit carry-lookahead slice: sum bits, per-bit carries and the
// group generate/propagate pair used by the inter-group ripple chain.
module cla4_group
    import adder_pkg::*;
(
    input  logic [CLA_GROUP-1:0] x,
    input  logic [CLA_GROUP-1:0] y,
    input  logic                 c_in,
    output logic [CLA_GROUP-1:0] s,
    output logic                 g_grp,
    output logic                 p_grp,
    output logic [CLA_GROUP-1:0] c
);

    logic [CLA_GROUP-1:0] p;
    logic [CLA_GROUP-1:0] g;

    // Flattened lookahead equations so every carry in the group is two levels deep.
    always_comb begin
        p     = x ^ y;
        g     = x & y;
        c[0]  = c_in;
        c[1]  = g[0] | (p[0] & c_in);
        c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
        c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c_in);
        g_grp = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
        p_grp = &p;
        s     = p ^ c;
    end

endmodule

// File: rtl/adder_n.sv
// Registered N-bit unsigned adder: {cout, sum} = a + b + cin, one cycle latency,
// built from 4-bit lookahead groups with a rippled group carry.
module adder_n
    import adder_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NG = num_groups(WIDTH);
    localparam int PW = NG * CLA_GROUP;

    logic [PW-1:0]    a_pad;
    logic [PW-1:0]    b_pad;
    logic [PW-1:0]    s_pad;
    logic [PW:0]      bit_c;
    logic [NG:0]      grp_c;
    logic [NG-1:0]    grp_g;
    logic [NG-1:0]    grp_p;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_d;
    logic             cout_q;
    logic             unused_bits;

    // Zero-pad operands up to a whole number of lookahead groups.
    always_comb begin
        a_pad             = '0;
        b_pad             = '0;
        a_pad[WIDTH-1:0]  = a;
        b_pad[WIDTH-1:0]  = b;
    end

    assign grp_c[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < NG; gi++) begin : g_grp_slice
            cla4_group u_grp (
                .x     (a_pad[gi*CLA_GROUP +: CLA_GROUP]),
                .y     (b_pad[gi*CLA_GROUP +: CLA_GROUP]),
                .c_in  (grp_c[gi]),
                .s     (s_pad[gi*CLA_GROUP +: CLA_GROUP]),
                .g_grp (grp_g[gi]),
                .p_grp (grp_p[gi]),
                .c     (bit_c[gi*CLA_GROUP +: CLA_GROUP])
            );
            assign grp_c[gi+1] = grp_g[gi] | (grp_p[gi] & grp_c[gi]);
        end
    endgenerate

    assign bit_c[PW] = grp_c[NG];

    // Carry out is the carry into bit WIDTH, which differs from the last
    // group carry whenever padding bits are present.
    always_comb begin
        sum_d  = s_pad[WIDTH-1:0];
        cout_d = bit_c[WIDTH];
    end

    // Pad-position sum bits and internal carries drive no output.
    assign unused_bits = ^{s_pad, bit_c};

    // Output register; reset wins over a new result.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_adder_n.sv
// Directed and random checks of adder_n at WIDTH 64, 7 and 13.
module tb_adder_n;

    logic        clk;
    logic        rst;
    logic [63:0] a64, b64, sum64;
    logic [12:0] a13, b13, sum13;
    logic [6:0]  a7, b7, sum7;
    logic        cin, cout64, cout13, cout7;

    int total;
    int passed;

    adder_n #(.WIDTH(64)) dut64 (
        .clk(clk), .rst(rst), .a(a64), .b(b64), .cin(cin), .sum(sum64), .cout(cout64)
    );
    adder_n #(.WIDTH(13)) dut13 (
        .clk(clk), .rst(rst), .a(a13), .b(b13), .cin(cin), .sum(sum13), .cout(cout13)
    );
    adder_n #(.WIDTH(7)) dut7 (
        .clk(clk), .rst(rst), .a(a7), .b(b7), .cin(cin), .sum(sum7), .cout(cout7)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive all instances from one 64-bit vector (narrow ones take low bits),
    // then step one edge and settle 1 ns past it.
    task automatic applyStimulus(input logic [63:0] av, input logic [63:0] bv,
                                 input logic cv, input logic rv);
        a64 = av;
        b64 = bv;
        a13 = av[12:0];
        b13 = bv[12:0];
        a7  = av[6:0];
        b7  = bv[6:0];
        cin = cv;
        rst = rv;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [64:0] obs,
                               input logic [64:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Directed steps followed by a random regression with reset pulses.
    initial begin
        logic [63:0] ra, rb;
        logic        rc, rr;
        logic [64:0] exp64;
        logic [13:0] exp13;

        total  = 0;
        passed = 0;

        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        checkOutput("reset_edge1_w64", {cout64, sum64}, 65'h0);
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        checkOutput("reset_edge2_w64", {cout64, sum64}, 65'h0);
        checkOutput("reset_edge2_w7", {57'h0, cout7, sum7}, 65'h0);
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        checkOutput("release_allones_w64", {cout64, sum64}, {1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
        checkOutput("release_allones_w7", {57'h0, cout7, sum7}, {57'h0, 1'b1, 7'h7F});
        checkOutput("release_allones_w13", {51'h0, cout13, sum13}, {51'h0, 1'b1, 13'h1FFF});

        applyStimulus(64'd0, 64'd0, 1'b0, 1'b0);
        checkOutput("zero_w64", {cout64, sum64}, 65'h0);

        applyStimulus(64'd5, 64'd3, 1'b0, 1'b0);
        checkOutput("basic_5p3", {cout64, sum64}, 65'd8);
        a64 = 64'd1;
        b64 = 64'd1;
        cin = 1'b1;
        #2;
        checkOutput("hold_before_edge", {cout64, sum64}, 65'd8);
        applyStimulus(64'd1, 64'd1, 1'b1, 1'b0);
        checkOutput("basic_1p1p1", {cout64, sum64}, 65'd3);

        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0);
        checkOutput("ripple_allones_cin", {cout64, sum64}, {1'b1, 64'h0});
        applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        checkOutput("ripple_to_msb", {cout64, sum64}, {1'b0, 64'h8000_0000_0000_0000});

        // 11 + 6 + 1 = 18: low nibble wraps to 2, the carry lands in bit 4.
        applyStimulus(64'hB, 64'h6, 1'b1, 1'b0);
        checkOutput("narrow_low_nibble", {61'h0, sum64[3:0]}, 65'h2);
        checkOutput("narrow_full", {cout64, sum64}, 65'h12);

        applyStimulus(64'h7F, 64'h01, 1'b0, 1'b0);
        checkOutput("w7_wrap", {57'h0, cout7, sum7}, {57'h0, 1'b1, 7'h00});
        applyStimulus(64'h40, 64'h3F, 1'b0, 1'b0);
        checkOutput("w7_no_carry", {57'h0, cout7, sum7}, {57'h0, 1'b0, 7'h7F});

        applyStimulus(64'd9, 64'd9, 1'b1, 1'b1);
        checkOutput("midstream_reset", {cout64, sum64}, 65'h0);

        for (int i = 0; i < 10000; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (i % 97 == 5) ra = 64'hFFFF_FFFF_FFFF_FFFF;
            rc = 1'($urandom_range(0, 1));
            rr = ($urandom_range(0, 63) == 0);
            if (rr) begin
                exp64 = 65'h0;
                exp13 = 14'h0;
            end else begin
                exp64 = {1'b0, ra} + {1'b0, rb} + {64'h0, rc};
                exp13 = {1'b0, ra[12:0]} + {1'b0, rb[12:0]} + {13'h0, rc};
            end
            applyStimulus(ra, rb, rc, rr);
            checkOutput("random_w64", {cout64, sum64}, exp64);
            checkOutput("random_w13", {51'h0, cout13, sum13}, {51'h0, exp13});
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
